// File: rtl/dbus_wb_if_pkg.sv
// Shared definitions for the CPU-to-Wishbone bus bridge: bus widths,
// the all-zero word and the bridge state encoding.
package dbus_wb_if_pkg;

    localparam int REG_BUS_W = 32;
    localparam int STALL_W   = 6;
    localparam int SEL_W     = 4;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE           = 2'b00,
        ST_BUSY           = 2'b01,
        ST_WAIT_FOR_STALL = 2'b10
    } wb_state_e;

endpackage

// File: rtl/dbus_wb_if.sv
// Bridge between a pipeline memory-access stage and a Wishbone classic master.
// One access is in flight at a time; the pipeline is stalled while the slave
// has not acknowledged, and read data is held for the CPU while ctrl keeps
// the pipeline stalled after the acknowledge.
//
// Handshake: a request is offered while cpu_ce_i=1 and must stay stable while
// stallreq_o=1. The Wishbone cycle starts with stb/cyc high on the edge after
// the request is seen in IDLE and ends on the edge where wishbone_ack_i=1 is
// sampled; flush_i aborts the cycle and discards any read data.
module dbus_wb_if
    import dbus_wb_if_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall_i,
    input  logic                 flush_i,
    input  logic                 cpu_ce_i,
    input  logic                 cpu_we_i,
    input  logic [SEL_W-1:0]     cpu_sel_i,
    input  logic [REG_BUS_W-1:0] cpu_addr_i,
    input  logic [REG_BUS_W-1:0] cpu_data_i,
    output logic [REG_BUS_W-1:0] cpu_data_o,
    output logic                 stallreq_o,
    input  logic [REG_BUS_W-1:0] wishbone_data_i,
    input  logic                 wishbone_ack_i,
    output logic [REG_BUS_W-1:0] wishbone_addr_o,
    output logic [REG_BUS_W-1:0] wishbone_data_o,
    output logic                 wishbone_we_o,
    output logic [SEL_W-1:0]     wishbone_sel_o,
    output logic                 wishbone_stb_o,
    output logic                 wishbone_cyc_o,
    output logic [1:0]           state_dbg
);

    wb_state_e            state;
    logic [REG_BUS_W-1:0] rd_buf;

    assign state_dbg = state;

    // Bridge FSM: owns every registered Wishbone output and the read buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            wishbone_addr_o <= ZERO_WORD;
            wishbone_data_o <= ZERO_WORD;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
            rd_buf          <= ZERO_WORD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wishbone_addr_o <= cpu_addr_i;
                        wishbone_data_o <= cpu_data_i;
                        wishbone_we_o   <= cpu_we_i;
                        wishbone_sel_o  <= cpu_sel_i;
                        wishbone_stb_o  <= 1'b1;
                        wishbone_cyc_o  <= 1'b1;
                        state           <= ST_BUSY;
                    end else begin
                        wishbone_addr_o <= ZERO_WORD;
                        wishbone_data_o <= ZERO_WORD;
                        wishbone_we_o   <= 1'b0;
                        wishbone_sel_o  <= '0;
                        wishbone_stb_o  <= 1'b0;
                        wishbone_cyc_o  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Flush wins over a same-cycle acknowledge.
                    if (flush_i || wishbone_ack_i) begin
                        wishbone_addr_o <= ZERO_WORD;
                        wishbone_data_o <= ZERO_WORD;
                        wishbone_we_o   <= 1'b0;
                        wishbone_sel_o  <= '0;
                        wishbone_stb_o  <= 1'b0;
                        wishbone_cyc_o  <= 1'b0;
                        if (flush_i) begin
                            rd_buf <= ZERO_WORD;
                            state  <= ST_IDLE;
                        end else begin
                            rd_buf <= wishbone_data_i;
                            state  <= (stall_i != '0) ? ST_WAIT_FOR_STALL : ST_IDLE;
                        end
                    end
                end
                ST_WAIT_FOR_STALL: begin
                    if (flush_i) begin
                        rd_buf <= ZERO_WORD;
                        state  <= ST_IDLE;
                    end else if (stall_i == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // CPU-side stall request and read data, combinational from state and inputs.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = ZERO_WORD;
        case (state)
            ST_IDLE: stallreq_o = cpu_ce_i && !flush_i;
            ST_BUSY: begin
                stallreq_o = !wishbone_ack_i;
                // A flushed access delivers nothing even if acked this cycle.
                if (wishbone_ack_i && !wishbone_we_o && !flush_i)
                    cpu_data_o = wishbone_data_i;
            end
            ST_WAIT_FOR_STALL: cpu_data_o = rd_buf;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dbus_wb_if.sv
// Directed bench for dbus_wb_if: a transaction-level reference model checked
// against the DUT every cycle, plus literal checks at key points.
module tb_dbus_wb_if;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i, cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_addr_i, cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;
  logic [31:0] wishbone_addr_o, wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o, wishbone_cyc_o;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  dbus_wb_if dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o),
    .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
    .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
    .wishbone_we_o(wishbone_we_o), .wishbone_sel_o(wishbone_sel_o),
    .wishbone_stb_o(wishbone_stb_o), .wishbone_cyc_o(wishbone_cyc_o),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: one outstanding access, and read data held while stalled
  bit          m_active, m_hold;
  logic [31:0] m_addr, m_wdata, m_buf;
  logic [3:0]  m_sel;
  bit          m_we;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_hold = 0; m_buf = 0;
      m_addr = 0; m_wdata = 0; m_sel = 0; m_we = 0;
    end else if (m_active) begin
      if (flush_i) begin
        m_active = 0; m_buf = 0;
      end else if (wishbone_ack_i) begin
        m_active = 0; m_buf = wishbone_data_i; m_hold = (stall_i != 0);
      end
    end else if (m_hold) begin
      if (flush_i) begin
        m_hold = 0; m_buf = 0;
      end else if (stall_i == 0) begin
        m_hold = 0;
      end
    end else if (cpu_ce_i && !flush_i) begin
      m_active = 1; m_addr = cpu_addr_i; m_wdata = cpu_data_i;
      m_sel = cpu_sel_i; m_we = cpu_we_i;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] e_data;
      logic        e_stall;
      e_stall = (!m_active && !m_hold && cpu_ce_i && !flush_i) || (m_active && !wishbone_ack_i);
      if (m_hold) e_data = m_buf;
      else if (m_active && wishbone_ack_i && !m_we && !flush_i) e_data = wishbone_data_i;
      else e_data = 0;
      check("stallreq", {31'd0, stallreq_o}, {31'd0, e_stall});
      check("cpu_data", cpu_data_o, e_data);
      check("cyc", {31'd0, wishbone_cyc_o}, {31'd0, m_active});
      check("stb", {31'd0, wishbone_stb_o}, {31'd0, m_active});
      check("addr", wishbone_addr_o, m_active ? m_addr : 32'd0);
      check("wdata", wishbone_data_o, m_active ? m_wdata : 32'd0);
      check("we", {31'd0, wishbone_we_o}, {31'd0, m_active && m_we});
      check("sel", {28'd0, wishbone_sel_o}, {28'd0, m_active ? m_sel : 4'd0});
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] data);
    cpu_ce_i = 1; cpu_we_i = we; cpu_sel_i = sel; cpu_addr_i = addr; cpu_data_i = data;
  endtask

  task automatic idle_cpu();
    cpu_ce_i = 0; cpu_we_i = 0; cpu_sel_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
  endtask

  initial begin
    rst = 0; stall_i = 0; flush_i = 0; idle_cpu();
    wishbone_data_i = 0; wishbone_ack_i = 0;
    cycle(); cycle();
    check("rst_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    check("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
    check("rst_cpu_data", cpu_data_o, 32'd0);
    rst = 1;
    cmp_en = 1;
    cycle();

    // read, acked three cycles after stb
    request(0, 4'b1111, 32'h0000_0104, 32'h0);
    #1 check("rd_stallreq_idle", {31'd0, stallreq_o}, 32'd1);
    cycle();
    check("rd_stb", {31'd0, wishbone_stb_o}, 32'd1);
    check("rd_addr", wishbone_addr_o, 32'h0000_0104);
    cycle(); cycle();
    wishbone_ack_i = 1; wishbone_data_i = 32'hDEAD_BEEF;
    #1 check("rd_ack_data", cpu_data_o, 32'hDEAD_BEEF);
    check("rd_ack_stallreq", {31'd0, stallreq_o}, 32'd0);
    cycle();
    wishbone_ack_i = 0; wishbone_data_i = 0; idle_cpu();
    check("rd_done_stb", {31'd0, wishbone_stb_o}, 32'd0);
    check("rd_done_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    cycle();

    // write: slave data must not reach the CPU
    request(1, 4'b0100, 32'h0000_0200, 32'h00AB_0000);
    cycle();
    check("wr_we", {31'd0, wishbone_we_o}, 32'd1);
    check("wr_sel", {28'd0, wishbone_sel_o}, 32'd4);
    check("wr_data", wishbone_data_o, 32'h00AB_0000);
    wishbone_ack_i = 1; wishbone_data_i = 32'hFFFF_0000;
    #1 check("wr_cpu_data", cpu_data_o, 32'd0);
    cycle();
    wishbone_ack_i = 0; idle_cpu();
    cycle();

    // read acked while stalled: data held until stall clears
    request(0, 4'b1111, 32'h0000_0300, 32'h0);
    cycle();
    wishbone_ack_i = 1; wishbone_data_i = 32'h1234_5678; stall_i = 6'b000011;
    cycle();
    wishbone_ack_i = 0; wishbone_data_i = 0; idle_cpu();
    for (int i = 0; i < 4; i++) begin
      check("stall_hold", cpu_data_o, 32'h1234_5678);
      if (i < 3) cycle();
    end
    stall_i = 0;
    cycle();
    check("stall_released", cpu_data_o, 32'd0);
    cycle();

    // flush together with ack in BUSY
    request(0, 4'b1111, 32'h0000_0400, 32'h0);
    cycle();
    wishbone_ack_i = 1; wishbone_data_i = 32'hCAFE_F00D; flush_i = 1;
    #1 check("flush_no_data", cpu_data_o, 32'd0);
    cycle();
    wishbone_ack_i = 0; flush_i = 0; idle_cpu();
    check("flush_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    check("flush_buf", cpu_data_o, 32'd0);
    cycle();

    // flush while waiting on stall clears the held data
    request(0, 4'b0011, 32'h0000_0500, 32'h0);
    cycle();
    wishbone_ack_i = 1; wishbone_data_i = 32'h5555_AAAA; stall_i = 6'b100000;
    cycle();
    wishbone_ack_i = 0; idle_cpu();
    check("wait_data", cpu_data_o, 32'h5555_AAAA);
    flush_i = 1;
    cycle();
    flush_i = 0; stall_i = 0;
    check("wait_flush", cpu_data_o, 32'd0);
    cycle();

    // request with flush in IDLE is not issued
    request(0, 4'b1111, 32'h0000_0600, 32'h0); flush_i = 1;
    cycle();
    check("idle_flush_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    flush_i = 0;

    // back-to-back reads: second starts the cycle after the first ack
    cycle();
    wishbone_ack_i = 1; wishbone_data_i = 32'h0000_0601;
    cycle();
    request(0, 4'b1111, 32'h0000_0700, 32'h0);
    wishbone_ack_i = 0;
    cycle();
    check("b2b_stb", {31'd0, wishbone_stb_o}, 32'd1);
    check("b2b_addr", wishbone_addr_o, 32'h0000_0700);
    wishbone_ack_i = 1; wishbone_data_i = 32'h0000_0702;
    cycle();
    wishbone_ack_i = 0; idle_cpu();
    cycle();

    // asynchronous reset mid-BUSY, then a stray ack
    request(0, 4'b1111, 32'h0000_0800, 32'h0);
    cycle();
    check("pre_rst_cyc", {31'd0, wishbone_cyc_o}, 32'd1);
    #1 rst = 0;
    #1 check("async_rst_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    check("async_rst_stb", {31'd0, wishbone_stb_o}, 32'd0);
    idle_cpu();
    #4 rst = 1; wishbone_ack_i = 1; wishbone_data_i = 32'hBAD0_BAD0;
    cycle();
    check("stray_ack_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    check("stray_ack_data", cpu_data_o, 32'd0);
    wishbone_ack_i = 0;
    cycle(); cycle();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
